// File: rtl/maze_pkg.sv
// Shared maze constants, map contents and FSM state type for the tile fetcher.
package maze_pkg;

    localparam int unsigned TILE_BITS = 4;
    localparam int unsigned COLS      = 40;
    localparam int unsigned ROWS      = 30;
    localparam int unsigned H_ACTIVE  = 640;
    localparam int unsigned V_ACTIVE  = 480;
    localparam int unsigned V_TOTAL   = 525;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned TX_W      = 6;
    localparam int unsigned TY_W      = 5;
    localparam int unsigned CNT_W     = 10;
    localparam int unsigned ADJ_W     = 4;

    typedef logic [COLS-1:0] row_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        F_UP  = 3'd1,
        F_MID = 3'd2,
        F_DN  = 3'd3,
        F_PEL = 3'd4,
        SWAP  = 3'd5
    } fetch_state_t;

    // Bit c of a row is tile column c.
    localparam row_t W_FULL = 40'hFF_FFFF_FFFF;
    localparam row_t W_COR  = 40'h80_4000_0201;
    localparam row_t P_COR  = 40'h7F_BFFF_FDFE;

    localparam row_t WALL_MAP [ROWS] = '{
        W_FULL,
        40'h80_0000_0009,
        40'h80_0000_0005,
        W_COR, W_COR, W_COR, W_COR, W_COR, W_COR, W_COR, W_COR, W_COR, W_COR,
        W_COR, W_COR, W_COR, W_COR, W_COR, W_COR, W_COR, W_COR, W_COR, W_COR,
        W_COR, W_COR, W_COR, W_COR, W_COR, W_COR,
        W_FULL
    };

    // Row 2 deliberately places a pellet under the wall at column 2; the wall masks it.
    localparam row_t INIT_PELLETS [ROWS] = '{
        40'h00_0000_0000,
        40'h7F_FFFF_FFF6,
        40'h7F_FFFF_FFFE,
        P_COR, P_COR, P_COR, P_COR, P_COR, P_COR, P_COR, P_COR, P_COR, P_COR,
        P_COR, P_COR, P_COR, P_COR, P_COR, P_COR, P_COR, P_COR, P_COR, P_COR,
        P_COR, P_COR, P_COR, P_COR, P_COR, P_COR,
        40'h00_0000_0000
    };

    // Total pellets in the initial map.
    function automatic int unsigned count_pellets();
        int unsigned n;
        n = 0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            n += $countones(INIT_PELLETS[TY_W'(r)]);
        end
        return n;
    endfunction

    localparam int unsigned PELLET_TOTAL = count_pellets();

    // Wall row lookup; rows past the grid read as empty.
    function automatic row_t wall_row(input logic [TY_W-1:0] r);
        return (32'(r) < ROWS) ? WALL_MAP[r] : '0;
    endfunction

endpackage

// File: rtl/maze_tile_fetch_if.sv
// Pixel-coordinate, tile-flag and pellet-eat signals between VGA/game logic and the fetcher.
interface maze_tile_fetch_if;
    import maze_pkg::*;

    logic [COORD_W-1:0] DrawX;
    logic [COORD_W-1:0] DrawY;
    logic               level_reload;
    logic               eat_req;
    logic [TX_W-1:0]    eat_tx;
    logic [TY_W-1:0]    eat_ty;
    logic               eat_hit;
    logic [CNT_W-1:0]   pellets_left;
    logic               is_wall;
    logic               is_pellet;
    logic [ADJ_W-1:0]   adjacent_walls_vga;
    logic [COORD_W-1:0] DrawX_d;
    logic [COORD_W-1:0] DrawY_d;

    modport master (
        output DrawX, DrawY, level_reload, eat_req, eat_tx, eat_ty,
        input  eat_hit, pellets_left, is_wall, is_pellet, adjacent_walls_vga,
               DrawX_d, DrawY_d
    );

    modport slave (
        input  DrawX, DrawY, level_reload, eat_req, eat_tx, eat_ty,
        output eat_hit, pellets_left, is_wall, is_pellet, adjacent_walls_vga,
               DrawX_d, DrawY_d
    );

endinterface

// File: rtl/maze_tile_fetch_pellet_map_ram.sv
// Writable pellet map: one row read port, bit-clear port with hit detect, remaining count.
module pellet_map_ram
    import maze_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reload_i,
    input  logic [TY_W-1:0]  rd_row_i,
    output row_t             rd_data_c,
    input  logic             eat_req_i,
    input  logic [TX_W-1:0]  eat_tx_i,
    input  logic [TY_W-1:0]  eat_ty_i,
    output logic             eat_hit_o,
    output logic [CNT_W-1:0] pellets_left_o
);

    row_t             map_q [ROWS];
    row_t             map_d [ROWS];
    logic             eat_hit_q, eat_hit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_range_c;
    logic [TX_W-1:0]  tx_s_c;
    logic [TY_W-1:0]  ty_s_c;
    logic             hit_c;

    // Combinational row read for the fetch FSM.
    assign rd_data_c = (32'(rd_row_i) < ROWS) ? map_q[rd_row_i] : '0;

    // Eat target decode; reload discards a concurrent eat.
    always_comb begin
        in_range_c = (eat_tx_i < TX_W'(COLS)) && (eat_ty_i < TY_W'(ROWS));
        tx_s_c     = in_range_c ? eat_tx_i : '0;
        ty_s_c     = in_range_c ? eat_ty_i : '0;
        hit_c      = eat_req_i && !reload_i && in_range_c && map_q[ty_s_c][tx_s_c];
    end

    // Next map, hit flag and saturating pellet count.
    always_comb begin
        map_d     = map_q;
        eat_hit_d = hit_c;
        cnt_d     = cnt_q;
        if (reload_i) begin
            map_d = INIT_PELLETS;
            cnt_d = CNT_W'(PELLET_TOTAL);
        end else if (hit_c) begin
            map_d[ty_s_c][tx_s_c] = 1'b0;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Map and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_q     <= INIT_PELLETS;
            eat_hit_q <= 1'b0;
            cnt_q     <= CNT_W'(PELLET_TOTAL);
        end else begin
            map_q     <= map_d;
            eat_hit_q <= eat_hit_d;
            cnt_q     <= cnt_d;
        end
    end

    assign eat_hit_o      = eat_hit_q;
    assign pellets_left_o = cnt_q;

endmodule

// File: rtl/maze_tile_fetch.sv
// Per-pixel tile flags from line buffers prefetched during horizontal blanking.
module maze_tile_fetch
    import maze_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset_n,
    maze_tile_fetch_if.slave   bus
);

    fetch_state_t       state_q, state_d;
    logic [TY_W-1:0]    row_q, row_d;
    row_t               sh_up_q, sh_up_d, sh_mid_q, sh_mid_d;
    row_t               sh_dn_q, sh_dn_d, sh_pel_q, sh_pel_d;
    row_t               act_up_q, act_up_d, act_mid_q, act_mid_d;
    row_t               act_dn_q, act_dn_d, act_pel_q, act_pel_d;

    logic               is_wall_q, is_wall_d, is_pellet_q, is_pellet_d;
    logic [ADJ_W-1:0]   adj_q, adj_d;
    logic [COORD_W-1:0] drawx_q, drawx_d, drawy_q, drawy_d;

    logic [COORD_W-1:0] nl_c;
    logic [TY_W-1:0]    tgt_row_c;
    logic               start_c;
    row_t               eat_mask_c;
    row_t               pel_rd_c;
    logic               in_view_c;
    logic [TX_W-1:0]    col_c;

    pellet_map_ram u_pellet_map (
        .clk            (Clk),
        .rst_n          (Reset_n),
        .reload_i       (bus.level_reload),
        .rd_row_i       (row_q),
        .rd_data_c      (pel_rd_c),
        .eat_req_i      (bus.eat_req),
        .eat_tx_i       (bus.eat_tx),
        .eat_ty_i       (bus.eat_ty),
        .eat_hit_o      (bus.eat_hit),
        .pellets_left_o (bus.pellets_left)
    );

    // Next display line, its tile row, fetch trigger and the eat mask for the row in flight.
    always_comb begin
        nl_c       = (bus.DrawY == COORD_W'(V_TOTAL - 1)) ? '0 : bus.DrawY + COORD_W'(1);
        tgt_row_c  = TY_W'(nl_c >> TILE_BITS);
        start_c    = (bus.DrawX == COORD_W'(H_ACTIVE)) && (nl_c < COORD_W'(V_ACTIVE));
        eat_mask_c = '0;
        if (bus.eat_req && !bus.level_reload && (bus.eat_tx < TX_W'(COLS))
            && (bus.eat_ty == row_q)) begin
            eat_mask_c = row_t'(1) << bus.eat_tx;
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; reload aborts any fetch in progress.
    always_comb begin
        state_d = state_q;
        if (bus.level_reload) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_c) state_d = F_UP;
                F_UP:    state_d = F_MID;
                F_MID:   state_d = F_DN;
                F_DN:    state_d = F_PEL;
                F_PEL:   state_d = SWAP;
                SWAP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: shadow loads per state, shadow-to-active copy in SWAP.
    always_comb begin
        row_d     = row_q;
        sh_up_d   = sh_up_q;
        sh_mid_d  = sh_mid_q;
        sh_dn_d   = sh_dn_q;
        sh_pel_d  = sh_pel_q;
        act_up_d  = act_up_q;
        act_mid_d = act_mid_q;
        act_dn_d  = act_dn_q;
        act_pel_d = act_pel_q;
        if (bus.level_reload) begin
            // Active buffers keep showing the current line; only the half-built fetch is dropped.
            sh_up_d  = '0;
            sh_mid_d = '0;
            sh_dn_d  = '0;
            sh_pel_d = '0;
        end else begin
            case (state_q)
                IDLE:  if (start_c) row_d = tgt_row_c;
                F_UP:  sh_up_d  = (row_q == '0) ? '0 : wall_row(row_q - TY_W'(1));
                F_MID: sh_mid_d = wall_row(row_q);
                F_DN:  sh_dn_d  = (row_q == TY_W'(ROWS - 1)) ? '0 : wall_row(row_q + TY_W'(1));
                // Eats landing on this row after the read must not leave a stale pellet.
                F_PEL: sh_pel_d = pel_rd_c & ~eat_mask_c;
                SWAP: begin
                    act_up_d  = sh_up_q;
                    act_mid_d = sh_mid_q;
                    act_dn_d  = sh_dn_q;
                    act_pel_d = sh_pel_q & ~eat_mask_c;
                end
                default: ;
            endcase
        end
    end

    // Per-pixel tile flags; off-grid neighbours and blanking read as 0.
    always_comb begin
        in_view_c   = (bus.DrawX < COORD_W'(H_ACTIVE)) && (bus.DrawY < COORD_W'(V_ACTIVE));
        col_c       = TX_W'(bus.DrawX >> TILE_BITS);
        is_wall_d   = 1'b0;
        is_pellet_d = 1'b0;
        adj_d       = '0;
        drawx_d     = bus.DrawX;
        drawy_d     = bus.DrawY;
        if (bus.level_reload) begin
            drawx_d = '0;
            drawy_d = '0;
        end else if (in_view_c) begin
            is_wall_d   = act_mid_q[col_c];
            is_pellet_d = act_pel_q[col_c] & ~act_mid_q[col_c];
            adj_d[0]    = act_up_q[col_c];
            adj_d[1]    = (col_c == TX_W'(COLS - 1)) ? 1'b0 : act_mid_q[col_c + TX_W'(1)];
            adj_d[2]    = act_dn_q[col_c];
            adj_d[3]    = (col_c == '0) ? 1'b0 : act_mid_q[col_c - TX_W'(1)];
        end
    end

    // Line buffer and pixel output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            row_q       <= '0;
            sh_up_q     <= '0;
            sh_mid_q    <= '0;
            sh_dn_q     <= '0;
            sh_pel_q    <= '0;
            act_up_q    <= '0;
            act_mid_q   <= '0;
            act_dn_q    <= '0;
            act_pel_q   <= '0;
            is_wall_q   <= 1'b0;
            is_pellet_q <= 1'b0;
            adj_q       <= '0;
            drawx_q     <= '0;
            drawy_q     <= '0;
        end else begin
            row_q       <= row_d;
            sh_up_q     <= sh_up_d;
            sh_mid_q    <= sh_mid_d;
            sh_dn_q     <= sh_dn_d;
            sh_pel_q    <= sh_pel_d;
            act_up_q    <= act_up_d;
            act_mid_q   <= act_mid_d;
            act_dn_q    <= act_dn_d;
            act_pel_q   <= act_pel_d;
            is_wall_q   <= is_wall_d;
            is_pellet_q <= is_pellet_d;
            adj_q       <= adj_d;
            drawx_q     <= drawx_d;
            drawy_q     <= drawy_d;
        end
    end

    assign bus.is_wall            = is_wall_q;
    assign bus.is_pellet          = is_pellet_q;
    assign bus.adjacent_walls_vga = adj_q;
    assign bus.DrawX_d            = drawx_q;
    assign bus.DrawY_d            = drawy_q;

endmodule
